// File: rtl/wash_setting_selector_pkg.sv
// Shared tables and types for the wash temperature setting selector.
// Level-to-temperature table, wash mode constants, per-mode level limits
// and the selector FSM state type.
package wash_setting_pkg;

   // Temperature in degrees C for each level index 0..4
   localparam logic [7:0] LEVEL_TEMP [5] = '{8'd20, 8'd30, 8'd40, 8'd50, 8'd60};

   localparam int unsigned MODE_COTTON     = 0;
   localparam int unsigned MODE_SYNTHETICS = 1;
   localparam int unsigned MODE_DELICATES  = 2;
   localparam int unsigned MODE_QUICK      = 3;
   localparam int unsigned MODE_HEAVY      = 4;
   localparam int unsigned MODE_ECO        = 5;
   localparam int unsigned MODE_RINSE      = 6;
   localparam int unsigned MODE_SPIN       = 7;   // no heating table entry

   // Per-mode level limits, indexed by mode; spin-only entries are unused
   localparam logic [2:0] MODE_MIN [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
   localparam logic [2:0] MODE_MAX [8] = '{3'd4, 3'd3, 3'd1, 3'd4, 3'd4, 3'd2, 3'd0, 3'd0};
   localparam logic [2:0] MODE_DEF [8] = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd3, 3'd1, 3'd0, 3'd0};

   typedef enum logic [1:0] {
      S_LOAD,
      S_IDLE,
      S_LOCKED
   } state_t;

endpackage

// File: rtl/wash_setting_selector_btn_edge_detect.sv
// Rising-edge detector for a debounced front-panel button.
// pulse is high in the cycle the button is first sampled high, so the
// consumer acts on the same edge that captures the rise.
module btn_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   logic btn_q;

   // Remember the previous button level
   always_ff @(posedge clk) begin
      if (reset) btn_q <= 1'b0;
      else       btn_q <= btn;
   end

   assign pulse = btn & ~btn_q;

endmodule

// File: rtl/wash_setting_selector.sv
// Wash temperature setting selector.
// Holds the temperature level for the active wash mode with up/down
// buttons, per-mode limits, lock during the cycle and reload on mode change.
// Optional macro SETTING_WRAP_EN: stepping past a bound wraps to the
// opposite bound instead of saturating.
module wash_setting_selector
   import wash_setting_pkg::*;
#(
   parameter int unsigned VALUE_W    = 6,
   parameter int unsigned MODE_W     = 3,
   parameter int unsigned NUM_LEVELS = 5,
   parameter int unsigned LVL_W      = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [MODE_W-1:0]  wash_mode,
   input  logic               inc_btn,
   input  logic               dec_btn,
   input  logic               lock,
   output logic [VALUE_W-1:0] selected_value,
   output logic [LVL_W-1:0]   level_idx,
   output logic               mode_valid,
   output logic               at_min,
   output logic               at_max,
   output logic               changed
);

   state_t            state, state_nxt;
   logic [MODE_W-1:0] mode_q, mode_nxt;
   logic [LVL_W-1:0]  level_nxt;
   logic              valid_nxt;
   logic              changed_nxt;
   logic              inc_p, dec_p;
   logic [LVL_W-1:0]  lo, hi;

   function automatic logic mode_ok(input logic [MODE_W-1:0] m);
      return !$isunknown(m) && (32'(m) < MODE_SPIN);
   endfunction

   function automatic logic [LVL_W-1:0] mode_min(input logic [MODE_W-1:0] m);
      return LVL_W'(MODE_MIN[3'(m)]);
   endfunction

   function automatic logic [LVL_W-1:0] mode_max(input logic [MODE_W-1:0] m);
      return LVL_W'(MODE_MAX[3'(m)]);
   endfunction

   function automatic logic [LVL_W-1:0] mode_def(input logic [MODE_W-1:0] m);
      return LVL_W'(MODE_DEF[3'(m)]);
   endfunction

   function automatic logic [VALUE_W-1:0] level_temp(input logic [LVL_W-1:0] l);
      return (32'(l) < NUM_LEVELS) ? VALUE_W'(LEVEL_TEMP[3'(l)]) : '0;
   endfunction

   btn_edge_detect u_inc_edge (.clk(clk), .reset(reset), .btn(inc_btn), .pulse(inc_p));
   btn_edge_detect u_dec_edge (.clk(clk), .reset(reset), .btn(dec_btn), .pulse(dec_p));

   assign lo = mode_min(mode_q);
   assign hi = mode_max(mode_q);

   // Next state, next level and change pulse
   always_comb begin
      state_nxt   = state;
      level_nxt   = level_idx;
      mode_nxt    = mode_q;
      valid_nxt   = mode_valid;
      changed_nxt = 1'b0;
      unique case (state)
         S_LOAD: begin
            if (mode_ok(wash_mode)) begin
               level_nxt = mode_def(wash_mode);
               mode_nxt  = wash_mode;
               valid_nxt = 1'b1;
               state_nxt = lock ? S_LOCKED : S_IDLE;
            end else begin
               level_nxt = '0;
               valid_nxt = 1'b0;
            end
         end
         S_IDLE: begin
            if (wash_mode != mode_q) begin
               state_nxt = S_LOAD;
            end else if (lock) begin
               state_nxt = S_LOCKED;
            end else if (inc_p && !dec_p) begin
               if (level_idx < hi) begin
                  level_nxt   = level_idx + LVL_W'(1);
                  changed_nxt = 1'b1;
               end
`ifdef SETTING_WRAP_EN
               else if (lo != hi) begin
                  level_nxt   = lo;
                  changed_nxt = 1'b1;
               end
`endif
            end else if (dec_p && !inc_p) begin
               if (level_idx > lo) begin
                  level_nxt   = level_idx - LVL_W'(1);
                  changed_nxt = 1'b1;
               end
`ifdef SETTING_WRAP_EN
               else if (lo != hi) begin
                  level_nxt   = hi;
                  changed_nxt = 1'b1;
               end
`endif
            end
         end
         S_LOCKED: begin
            if (!lock) state_nxt = (wash_mode != mode_q) ? S_LOAD : S_IDLE;
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   // Registered state and outputs; derived outputs are computed from the
   // next level/mode so they stay aligned with level_idx in every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_LOAD;
         mode_q         <= '0;
         level_idx      <= '0;
         mode_valid     <= 1'b0;
         changed        <= 1'b0;
         selected_value <= '0;
         at_min         <= 1'b0;
         at_max         <= 1'b0;
      end else begin
         state          <= state_nxt;
         mode_q         <= mode_nxt;
         level_idx      <= level_nxt;
         mode_valid     <= valid_nxt;
         changed        <= changed_nxt;
         selected_value <= valid_nxt ? level_temp(level_nxt) : '0;
         at_min         <= valid_nxt && (level_nxt == mode_min(mode_nxt));
         at_max         <= valid_nxt && (level_nxt == mode_max(mode_nxt));
      end
   end

endmodule

// File: tb/tb_wash_setting_selector.sv
// Scoreboard bench for wash_setting_selector: the driver pushes expected
// output snapshots tagged with a cycle number, the monitor pops and compares
// them on the falling edge of that cycle.
module tb_wash_setting_selector;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] wash_mode;
   logic       inc_btn, dec_btn, lock;
   logic [5:0] selected_value;
   logic [2:0] level_idx;
   logic       mode_valid, at_min, at_max, changed;

   typedef struct {
      int    cyc;
      string name;
      int    val;
      int    lvl;
      bit    mv;
      bit    mn;
      bit    mx;
      bit    ch;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   wash_setting_selector #(
      .VALUE_W(6), .MODE_W(3), .NUM_LEVELS(5), .LVL_W(3)
   ) dut (
      .clk(clk), .reset(reset), .wash_mode(wash_mode),
      .inc_btn(inc_btn), .dec_btn(dec_btn), .lock(lock),
      .selected_value(selected_value), .level_idx(level_idx),
      .mode_valid(mode_valid), .at_min(at_min), .at_max(at_max),
      .changed(changed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due in this cycle
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (selected_value !== 6'(e.val) || level_idx !== 3'(e.lvl) ||
             mode_valid !== e.mv || at_min !== e.mn || at_max !== e.mx ||
             changed !== e.ch) begin
            errors++;
            $display("FAIL %s: got val=%0d lvl=%0d mv=%b min=%b max=%b chg=%b, want val=%0d lvl=%0d mv=%b min=%b max=%b chg=%b",
                     e.name, selected_value, level_idx, mode_valid, at_min, at_max, changed,
                     e.val, e.lvl, e.mv, e.mn, e.mx, e.ch);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input int v, input int l,
                             input bit mv, input bit mn, input bit mx, input bit ch);
      exp_t e;
      e.cyc = cyc; e.name = nm; e.val = v; e.lvl = l;
      e.mv = mv; e.mn = mn; e.mx = mx; e.ch = ch;
      sb.push_back(e);
   endtask

   initial begin
      reset = 1'b1; wash_mode = 3'd0; inc_btn = 1'b0; dec_btn = 1'b0; lock = 1'b0;
      tick(); tick();
      expect_out("reset", 0, 0, 0, 0, 0, 0);

      // Cotton loads its default level 2
      reset = 1'b0;
      tick();
      expect_out("load_cotton", 40, 2, 1, 0, 0, 0);
      tick();
      expect_out("idle_cotton", 40, 2, 1, 0, 0, 0);

      // Quick: mode change reloads on the following edge
      wash_mode = 3'd3;
      tick();
      expect_out("quick_pending", 40, 2, 1, 0, 0, 0);
      tick();
      expect_out("quick_load", 20, 0, 1, 1, 0, 0);

      // Five rising edges on inc
      for (int i = 0; i < 4; i++) begin
         inc_btn = 1'b1; tick();
         expect_out("quick_inc", 30 + 10 * i, i + 1, 1, 0, (i == 3), 1);
         inc_btn = 1'b0; tick();
         expect_out("quick_inc_rel", 30 + 10 * i, i + 1, 1, 0, (i == 3), 0);
      end
      inc_btn = 1'b1; tick();
`ifdef SETTING_WRAP_EN
      expect_out("quick_inc_top", 20, 0, 1, 1, 0, 1);
`else
      expect_out("quick_inc_top", 60, 4, 1, 0, 1, 0);
`endif
      inc_btn = 1'b0; tick();

      // Synthetics: held inc gives one step, simultaneous inc/dec does nothing
      wash_mode = 3'd1;
      tick(); tick();
      expect_out("synth_load", 30, 1, 1, 0, 0, 0);
      inc_btn = 1'b1; tick();
      expect_out("synth_inc", 40, 2, 1, 0, 0, 1);
      for (int i = 0; i < 9; i++) begin
         tick();
         expect_out("synth_held", 40, 2, 1, 0, 0, 0);
      end
      inc_btn = 1'b0; tick();
      inc_btn = 1'b1; dec_btn = 1'b1; tick();
      expect_out("synth_both", 40, 2, 1, 0, 0, 0);
      inc_btn = 1'b0; dec_btn = 1'b0; tick();
      dec_btn = 1'b1; tick();
      expect_out("synth_dec", 30, 1, 1, 0, 0, 1);
      dec_btn = 1'b0; tick();

      // Cotton, then lock: buttons and mode change frozen until unlock
      wash_mode = 3'd0;
      tick(); tick();
      expect_out("cotton_reload", 40, 2, 1, 0, 0, 0);
      lock = 1'b1; tick();
      inc_btn = 1'b1; tick();
      expect_out("locked_inc", 40, 2, 1, 0, 0, 0);
      inc_btn = 1'b0; wash_mode = 3'd4; tick(); tick();
      expect_out("locked_mode", 40, 2, 1, 0, 0, 0);
      lock = 1'b0; tick();
      expect_out("unlock_pending", 40, 2, 1, 0, 0, 0);
      tick();
      expect_out("heavy_load", 50, 3, 1, 0, 0, 0);

      // Button held across unlock does not step
      lock = 1'b1; tick();
      inc_btn = 1'b1; tick(); tick();
      lock = 1'b0; tick(); tick();
      expect_out("held_unlock", 50, 3, 1, 0, 0, 0);
      inc_btn = 1'b0; tick();

      // Spin-only has no table entry; buttons ignored
      wash_mode = 3'd7;
      tick(); tick();
      expect_out("spin_invalid", 0, 0, 0, 0, 0, 0);
      inc_btn = 1'b1; tick();
      expect_out("spin_inc", 0, 0, 0, 0, 0, 0);
      inc_btn = 1'b0; tick();

      // Rinse has a single level
      wash_mode = 3'd6;
      tick();
      expect_out("rinse_load", 20, 0, 1, 1, 1, 0);
      inc_btn = 1'b1; tick();
      expect_out("rinse_inc", 20, 0, 1, 1, 1, 0);
      inc_btn = 1'b0; dec_btn = 1'b1; tick();
      expect_out("rinse_dec", 20, 0, 1, 1, 1, 0);
      dec_btn = 1'b0; tick();

      // Quick: dec at min, then climb to the top and reset mid-sequence
      wash_mode = 3'd3;
      tick(); tick();
      expect_out("quick_reload", 20, 0, 1, 1, 0, 0);
      dec_btn = 1'b1; tick();
`ifdef SETTING_WRAP_EN
      expect_out("quick_dec_bottom", 60, 4, 1, 0, 1, 1);
      dec_btn = 1'b0; tick();
      inc_btn = 1'b1; tick(); inc_btn = 1'b0; tick();
      expect_out("quick_wrap_back", 20, 0, 1, 1, 0, 0);
`else
      expect_out("quick_dec_bottom", 20, 0, 1, 1, 0, 0);
      dec_btn = 1'b0; tick();
`endif
      for (int i = 0; i < 4; i++) begin
         inc_btn = 1'b1; tick(); inc_btn = 1'b0; tick();
      end
      expect_out("quick_top", 60, 4, 1, 0, 1, 0);
      reset = 1'b1; tick();
      expect_out("mid_reset", 0, 0, 0, 0, 0, 0);
      reset = 1'b0; tick();
      expect_out("post_reset", 20, 0, 1, 1, 0, 0);

      tick(); tick(); tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
